async_fifo_frame_writer: RTL

- Write-side producer for the async FIFO.
- Takes a length command and a valid/ready payload stream in the wr_clk domain.
- Emits one framed packet into the FIFO write port: a header word, the payload words, then an XOR checksum trailer.
- Obeys the FIFO's full flag, so no word is ever lost or duplicated. The read-domain consumer resyncs on the header magic.

---
 rtl/async_fifo_pkg.sv | 28 ++
 rtl/async_fifo_frame_writer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
//   Shared definitions for the async FIFO frame writer and its matching reader.
//   Frame layout on the FIFO: header word, payload words, XOR checksum trailer.
//   Header word: MAGIC tag in the top four bits, zero pad, payload length in
//   the low LEN_W bits.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    TRL  = 2'd3
  } frame_wr_state_e;

  // Header tag used by the reader to resynchronise on frame boundaries.
  localparam logic [3:0] MAGIC_DEFAULT = 4'hA;

  // Tag field position, counted downward from the word MSB so the same
  // constants hold for every DATA_WIDTH: bits [W-1-MSB : W-1-LSB].
  localparam int HDR_TAG_MSB = 0;
  localparam int HDR_TAG_LSB = 3;

  // Length field starts at bit 0 of the header word.
  localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/async_fifo_frame_writer.sv
// -----------------------------------------------------------------------------
// async_fifo_frame_writer
//   Write-side producer for the async FIFO. On start it frames len payload
//   words from a valid/ready stream as: header, payload, XOR checksum trailer,
//   honouring fifo_full so every word is written exactly once, in order.
//
// Ports (all in the wr_clk domain):
//   wr_clk, wr_rst  clock, asynchronous active-high reset
//   start, len      frame request and payload word count (sampled in IDLE)
//   s_valid, s_data upstream payload stream; s_ready back-pressure
//   fifo_full       FIFO full flag
//   fifo_wr_en      registered FIFO write enable
//   fifo_data       registered FIFO write data
//   busy            high while a frame is in progress
//   done            one-cycle pulse after the trailer is accepted
//   frame_cnt       completed-frame counter, wraps
// -----------------------------------------------------------------------------
module async_fifo_frame_writer
  import async_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         LEN_W      = 8,
  parameter logic [3:0] MAGIC      = MAGIC_DEFAULT,
  parameter int         CNT_W      = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      frame_cnt
);

  frame_wr_state_e       state_q, state_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;

  logic                  accept;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] hdr_word;

  // The FIFO has taken fifo_data only when write is requested and not full.
  assign accept = fifo_wr_en_q & ~fifo_full;

  // Only combinational path from fifo_full: a new payload word may be taken
  // when the output register is empty or is being drained this cycle.
  assign s_ready   = (state_q == DATA) & (rem_q != '0) & (~fifo_wr_en_q | ~fifo_full);
  assign handshake = s_valid & s_ready;

  always_comb begin
    hdr_word = '0;
    hdr_word[DATA_WIDTH-1-HDR_TAG_MSB : DATA_WIDTH-1-HDR_TAG_LSB] = MAGIC;
    hdr_word[HDR_LEN_LSB +: LEN_W] = len;
  end

  always_comb begin
    state_d      = state_q;
    fifo_wr_en_d = fifo_wr_en_q;
    fifo_data_d  = fifo_data_q;
    rem_d        = rem_q;
    csum_d       = csum_q;
    done_d       = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          fifo_data_d  = hdr_word;
          fifo_wr_en_d = 1'b1;
          rem_d        = len;
          csum_d       = '0;
          state_d      = HDR;
        end
      end

      HDR: begin
        if (accept) begin
          if (rem_q == '0) begin
            // Empty frame: trailer (zero checksum) follows the header directly.
            fifo_data_d = csum_q;
            state_d     = TRL;
          end else begin
            fifo_wr_en_d = 1'b0;
            state_d      = DATA;
          end
        end
      end

      DATA: begin
        if (handshake) begin
          fifo_data_d  = s_data;
          fifo_wr_en_d = 1'b1;
          csum_d       = csum_q ^ s_data;
          rem_d        = rem_q - LEN_W'(1);
        end else if (accept) begin
          fifo_wr_en_d = 1'b0;
        end
        // All payload taken: load the trailer as soon as the register frees,
        // so it follows the last payload word without a bubble.
        if ((rem_q == '0) && (~fifo_wr_en_q | accept)) begin
          fifo_data_d  = csum_q;
          fifo_wr_en_d = 1'b1;
          state_d      = TRL;
        end
      end

      TRL: begin
        if (accept) begin
          fifo_wr_en_d = 1'b0;
          done_d       = 1'b1;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q      <= IDLE;
      fifo_wr_en_q <= 1'b0;
      fifo_data_q  <= '0;
      rem_q        <= '0;
      csum_q       <= '0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      fifo_data_q  <= fifo_data_d;
      rem_q        <= rem_d;
      csum_q       <= csum_d;
      done_q       <= done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign fifo_wr_en = fifo_wr_en_q;
  assign fifo_data  = fifo_data_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
